debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Parametrised multi-channel debouncer; successor to the single-channel shift-register debouncer.
//  Each channel: metastability synchroniser -> per-channel counter FSM that requires STABLE_CYC
//  consecutive equal samples before the clean level changes -> one-cycle rise/fall pulses.
//  Sits between raw board buttons/switches and any synchronous consumer logic.
// PARAMETERS
//  N_CH        4     number of independent input channels (>=1)
//  SYNC_STAGES 2     synchroniser flops per channel (>=2)
//  STABLE_CYC  16    consecutive stable synchronised cycles needed to accept a new level (>=2)
//  LONG_CYC    1000  cycles btn_out must stay high before long_press fires (>=1; macro only)
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  clr         in   1     synchronous, active-low reset (0 = clear on next posedge)
//  btn_in      in   N_CH  raw bouncing inputs, asynchronous to clk
//  btn_out     out  N_CH  debounced levels
//  rise        out  N_CH  1-cycle pulse when btn_out[i] goes 0->1
//  fall        out  N_CH  1-cycle pulse when btn_out[i] goes 1->0
//  long_press  out  N_CH  1-cycle pulse per press held LONG_CYC cycles (tied 0 without macro)
// BEHAVIOUR
//  - Reset (clr=0 at posedge): sync flops=0, FSM=IDLE_LO, counters=0, btn_out/rise/fall/long_press=0.
//  - s = last synchroniser stage. FSM states per channel: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
//  - IDLE_LO: s=1 -> WAIT_HI, cnt=1. Else stay.
//  - WAIT_HI: s=0 -> IDLE_LO, cnt=0 (bounce aborts, no pulse). s=1 & cnt==STABLE_CYC-1 ->
//    IDLE_HI, btn_out=1, rise=1 for that cycle. Else cnt++.
//  - IDLE_HI / WAIT_LO: mirror image; acceptance sets btn_out=0, fall=1.
//  - Latency: btn_out/pulse change registered on the (SYNC_STAGES+STABLE_CYC)-th posedge, counting
//    the first posedge that samples the new level, provided the level holds throughout.
//  - Pulses < STABLE_CYC synchronised cycles never reach btn_out. rise and fall never both 1.
//  - Counter width $clog2(STABLE_CYC); never wraps (cleared on every state exit).
//  - Channels fully independent; any combination may pulse in the same cycle.
//  - Reset mid-qualification discards progress; after release, a held input re-qualifies from
//    scratch and produces exactly one rise.
// CONFIGURATION
//  Macro DEBOUNCE_LONGPRESS_EN:
//  - Defined: per-channel hold counter runs only in IDLE_HI/WAIT_LO, cleared on entering IDLE_HI and
//    in reset; long_press[i]=1 for one cycle when it reaches LONG_CYC cycles after rise[i]; counter
//    saturates -> one pulse per press; a fall before LONG_CYC gives no pulse.
//  - Undefined: no hold counter synthesised, long_press driven constant 0, LONG_CYC ignored.
// STRUCTURE
//  - Package debounce_pkg: state typedef (2-bit enum IDLE_LO/WAIT_HI/IDLE_HI/WAIT_LO), clog2-based
//    counter width function, default parameter constants.
//  - Sub-module debounce_ch: one synchroniser+FSM+counter(+hold counter) channel; debounce_multi
//    instantiates N_CH copies in a generate loop and concatenates outputs.
// TESTING  (N_CH=4, SYNC_STAGES=2, STABLE_CYC=4, LONG_CYC=10)
//  1 Reset: btn_in=4'hF, clr=0 for 3 cycles -> all outputs 0; clr=1 -> btn_out=4'hF and rise=4'hF
//    (one cycle) on 6th posedge after release, then rise=0.
//  2 Bounce: btn_in[0] 1,0,1,0 per cycle then held 1 -> btn_out[0] rises 6 posedges after the final
//    0->1 sample; exactly one rise[0] pulse, channels 1-3 stay 0.
//  3 Glitch: btn_in[1]=1 for 3 cycles then 0 -> btn_out[1], rise[1], fall[1] stay 0 throughout.
//  4 Release: btn_out[2]=1, btn_in[2]->0 -> btn_out[2]=0 and fall[2]=1 (one cycle) 6 posedges later.
//  5 Reset mid-qualify: btn_in[3]=1, clr=0 for 1 cycle at cnt=2, input held -> no rise before
//    reset; single rise[3] 6 posedges after clr returns 1.
//  6 Long press (macro defined): hold btn_in[0] -> long_press[0]=1 exactly once, 10 cycles after
//    rise[0]; release at 5 cycles -> none; macro undefined -> long_press always 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t    per-channel qualification state
//   cnt_width  counter width helper (never returns 0)
//   DEF_*      default parameter values used by debounce_multi / debounce_ch
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CYC  = 16;
  localparam int DEF_LONG_CYC    = 1000;

  // Bits needed to hold values 0..n-1, with a floor of one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter FSM, edge pulses, optional hold detector.
// Latency: level/pulse registered SYNC_STAGES+STABLE_CYC posedges after a stable input change.
// Backpressure: none; free-running, outputs are always valid.
//
// Optional feature: define DEBOUNCE_LONGPRESS_EN to build the long-press hold counter.
//
// Ports:
//   clk         in   system clock, posedge
//   clr         in   synchronous active-low clear
//   btn         in   raw input, asynchronous to clk
//   level       out  debounced level
//   rise        out  one-cycle pulse on level 0->1
//   fall        out  one-cycle pulse on level 1->0
//   long_press  out  one-cycle pulse when level has been high LONG_CYC cycles (0 without macro)
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int LONG_CYC    = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  if (SYNC_STAGES < 2 || STABLE_CYC < 2 || LONG_CYC < 1) begin : g_bad_param
    $error("debounce_ch: SYNC_STAGES>=2, STABLE_CYC>=2 and LONG_CYC>=1 are required");
  end

  localparam int CW = cnt_width(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (!clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------- qualification FSM ----------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter is cleared on every state exit, so it can never run past CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

  // ---------------- long-press hold counter ----------------
`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int HW = cnt_width(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYC - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          lp_q, lp_d;

  always_ff @(posedge clk) begin
    if (!clr) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  // Cleared on the accepted rise only: a bounce that drops WAIT_LO back into
  // IDLE_HI is still the same press and must not re-arm the pulse.
  // Saturating at LONG_CYC gives exactly one pulse per press.
  always_comb begin
    hold_d = hold_q;
    lp_d   = 1'b0;
    if (rise_d) begin
      hold_d = '0;
    end else if ((state_q == IDLE_HI || state_q == WAIT_LO) && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HW'(1);
      lp_d   = (hold_q == HOLD_FIRE);
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer: N_CH independent debounce_ch instances.
// Latency: SYNC_STAGES+STABLE_CYC posedges from a stable input change to btn_out/rise/fall.
// Backpressure: none; outputs are level/pulse signals with no handshake.
//
// Optional feature: define DEBOUNCE_LONGPRESS_EN to enable long_press (tied 0 otherwise).
//
// Ports:
//   clk         in   [1]     system clock, posedge
//   clr         in   [1]     synchronous active-low clear
//   btn_in      in   [N_CH]  raw bouncing inputs, asynchronous to clk
//   btn_out     out  [N_CH]  debounced levels
//   rise        out  [N_CH]  one-cycle pulse per channel on btn_out 0->1
//   fall        out  [N_CH]  one-cycle pulse per channel on btn_out 1->0
//   long_press  out  [N_CH]  one-cycle pulse per press held LONG_CYC cycles
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int LONG_CYC    = DEF_LONG_CYC
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  if (N_CH < 1) begin : g_bad_param
    $error("debounce_multi: N_CH must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_ch (
      .clk        (clk),
      .clr        (clr),
      .btn        (btn_in[i]),
      .level      (btn_out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (N_CH=4, SYNC_STAGES=2, STABLE_CYC=4, LONG_CYC=10).
// Expected pulse events are queued with their due cycle when stimulus is driven and
// compared each cycle against rise/fall/long_press; levels are checked at step boundaries.
module tb_debounce_multi;

  localparam int N_CH = 4;
  localparam int LAT  = 6;   // SYNC_STAGES + STABLE_CYC
  localparam int LONG = 10;

  logic            clk = 1'b0;
  logic            clr;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_out, rise, fall, long_press;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] r;
    logic [N_CH-1:0] f;
    logic [N_CH-1:0] lp;
    string           tag;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  debounce_multi #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .STABLE_CYC  (4),
    .LONG_CYC    (LONG)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_in     (btn_in),
    .btn_out    (btn_out),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  task automatic push(input int dly, input logic [N_CH-1:0] r, input logic [N_CH-1:0] f,
                      input logic [N_CH-1:0] lp, input string tag);
    exp_q.push_back('{cyc + dly, r, f, lp, tag});
  endtask

  task automatic check_eq(input string tag, input logic [N_CH-1:0] got, input logic [N_CH-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Advance n posedges; after each, compare pulse outputs with the scoreboard.
  task automatic step(input int n);
    ev_t  e;
    logic pulse;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      tests++;
      assert ((rise & fall) === '0) else begin
        fails++;
        $error("FAIL rise_fall_overlap: observed rise=%h fall=%h expected no overlap", rise, fall);
      end
      pulse = |{rise, fall, long_press};
      if (exp_q.size() > 0 && (pulse || exp_q[0].cyc <= cyc)) begin
        e = exp_q.pop_front();
        tests++;
        assert (cyc == e.cyc && rise === e.r && fall === e.f && long_press === e.lp) else begin
          fails++;
          $error("FAIL %s: observed cyc=%0d rise=%h fall=%h lp=%h expected cyc=%0d rise=%h fall=%h lp=%h",
                 e.tag, cyc, rise, fall, long_press, e.cyc, e.r, e.f, e.lp);
        end
      end else begin
        tests++;
        assert (!pulse) else begin
          fails++;
          $error("FAIL unexpected_pulse: observed rise=%h fall=%h lp=%h expected none (cycle %0d)",
                 rise, fall, long_press, cyc);
        end
      end
    end
  endtask

  initial begin
    // 1: reset with inputs high, then release
    clr    = 1'b0;
    btn_in = 4'hF;
    step(3);
    check_eq("reset_btn_out", btn_out, 4'h0);
    check_eq("reset_rise", rise, 4'h0);
    check_eq("reset_fall", fall, 4'h0);
    check_eq("reset_long_press", long_press, 4'h0);
    clr = 1'b1;
    push(LAT, 4'hF, 4'h0, 4'h0, "release_rise");
    step(LAT + 2);
    check_eq("release_level", btn_out, 4'hF);

    // bring everything low again
    btn_in = 4'h0;
    push(LAT, 4'h0, 4'hF, 4'h0, "all_fall");
    step(LAT + 2);
    check_eq("all_low", btn_out, 4'h0);

    // 2: bounce on ch0, then held high
    btn_in = 4'h1; step(1);
    btn_in = 4'h0; step(1);
    btn_in = 4'h1; step(1);
    btn_in = 4'h0; step(1);
    btn_in = 4'h1;
    push(LAT, 4'h1, 4'h0, 4'h0, "bounce_rise");
`ifdef DEBOUNCE_LONGPRESS_EN
    push(LAT + LONG, 4'h0, 4'h0, 4'h1, "ch0_long");
`endif
    step(LAT + 3);
    check_eq("bounce_level", btn_out, 4'h1);

    // 3: 3-cycle glitch on ch1 never qualifies
    btn_in = 4'h3;
    step(3);
    btn_in = 4'h1;
    step(10);
    check_eq("glitch_level", btn_out, 4'h1);

    // 4: ch2 press and release
    btn_in = 4'h5;
    push(LAT, 4'h4, 4'h0, 4'h0, "ch2_rise");
    step(LAT + 2);
    check_eq("ch2_high", btn_out, 4'h5);
    btn_in = 4'h1;
    push(LAT, 4'h0, 4'h4, 4'h0, "ch2_fall");
    step(LAT + 2);
    check_eq("ch2_low", btn_out, 4'h1);

    // 5: reset while ch3 is qualifying (cnt=2), input held through reset
    btn_in = 4'h9;
    step(4);
    clr = 1'b0;
    step(1);
    check_eq("midreset_level", btn_out, 4'h0);
    clr = 1'b1;
    push(LAT, 4'h9, 4'h0, 4'h0, "requalify_rise");
`ifdef DEBOUNCE_LONGPRESS_EN
    push(LAT + LONG, 4'h0, 4'h0, 4'h9, "requalify_long");
`endif
    step(LAT + 2);
    check_eq("requalify_level", btn_out, 4'h9);
    step(12);

    // 6a: short press on ch1 released right after rise -> no long_press
    btn_in = 4'hB;
    push(LAT, 4'h2, 4'h0, 4'h0, "short_rise");
    step(LAT);
    btn_in = 4'h9;
    push(LAT, 4'h0, 4'h2, 4'h0, "short_fall");
    step(15);
    check_eq("short_level", btn_out, 4'h9);

    // 6b: long hold on ch2 -> one long_press (macro) or none
    btn_in = 4'hD;
    push(LAT, 4'h4, 4'h0, 4'h0, "hold_rise");
`ifdef DEBOUNCE_LONGPRESS_EN
    push(LAT + LONG, 4'h0, 4'h0, 4'h4, "hold_long");
`endif
    step(LAT + LONG + 10);
    check_eq("hold_level", btn_out, 4'hD);
    check_eq("hold_long_press_idle", long_press, 4'h0);
    btn_in = 4'h0;
    push(LAT, 4'h0, 4'hD, 4'h0, "final_fall");
    step(LAT + 2);
    check_eq("final_level", btn_out, 4'h0);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending events expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
